// File: rtl/oddeven_sort_ctrl.sv
// Frame controller for the odd-even parallel sort core.
// Gathers up to N elements from an input stream into a parallel word, pulses
// the core load, waits a fixed sort latency, captures the sorted word and
// streams the first frame_len elements out in ascending order.
module oddeven_sort_ctrl #(
  parameter int           N           = 16,
  parameter int           W           = 8,
  parameter int           SORT_CYCLES = N,
  parameter logic [W-1:0] PAD         = {W{1'b1}}
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           flush,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic           in_ready,
  output logic           core_load,
  output logic [W*N-1:0] core_data_in,
  input  logic [W*N-1:0] core_data_out,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic           busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(N + 1);
  localparam int SW = $clog2(SORT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_LOAD  = 2'd1,
    S_SORT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [W-1:0]    r_in_buf  [N];
  logic [W-1:0]    r_out_buf [N];
  logic [CW-1:0]   r_wr_cnt;
  logic [CW-1:0]   r_rd_cnt;
  logic [LW-1:0]   r_frame_len;
  logic [SW-1:0]   r_sort_cnt;

  logic            w_in_hs;
  logic            w_in_end;
  logic            w_sort_done;
  logic            w_out_hs;
  logic            w_out_end;
  logic            w_is_last;

  assign w_in_hs     = (r_state == S_FILL) && in_valid;
  // The element landing in the top slot closes the frame even with in_last,
  // so a full frame marked last is still a single frame.
  assign w_in_end    = w_in_hs && ((r_wr_cnt == CW'(N - 1)) || in_last);
  // The counter is one past the sort window when the core result is captured.
  assign w_sort_done = (r_state == S_SORT) && (r_sort_cnt == SW'(SORT_CYCLES));
  assign w_is_last   = (LW'(r_rd_cnt) == (r_frame_len - LW'(1)));
  assign w_out_hs    = (r_state == S_DRAIN) && out_ready;
  assign w_out_end   = w_out_hs && w_is_last;

  // Present the input buffer to the core as one parallel word.
  for (genvar gi = 0; gi < N; gi++) begin : g_core_in
    assign core_data_in[W*gi +: W] = r_in_buf[gi];
  end

  // State register; flush acts as a synchronous return to FILL.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_FILL;
    end else if (flush) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and stream/core control outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    core_load    = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;
    busy         = 1'b1;
    case (r_state)
      S_FILL: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (w_in_end) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        core_load    = 1'b1;
        w_state_next = S_SORT;
      end
      S_SORT: begin
        if (w_sort_done) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = w_is_last;
        out_data  = r_out_buf[r_rd_cnt];
        if (w_out_end) w_state_next = S_FILL;
      end
      default: w_state_next = S_FILL;
    endcase
  end

  // Buffers and counters; the end of a drain restores the idle contents.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < N; i++) begin
        r_in_buf[i]  <= PAD;
        r_out_buf[i] <= PAD;
      end
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_frame_len <= '0;
      r_sort_cnt  <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) begin
        r_in_buf[i]  <= PAD;
        r_out_buf[i] <= PAD;
      end
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_frame_len <= '0;
      r_sort_cnt  <= '0;
    end else begin
      if (w_in_hs) begin
        r_in_buf[r_wr_cnt] <= in_data;
        if (w_in_end) r_frame_len <= LW'(r_wr_cnt) + LW'(1);
        else          r_wr_cnt    <= r_wr_cnt + CW'(1);
      end
      if (r_state == S_SORT) begin
        if (w_sort_done) begin
          for (int i = 0; i < N; i++) r_out_buf[i] <= core_data_out[W*i +: W];
        end else begin
          r_sort_cnt <= r_sort_cnt + SW'(1);
        end
      end
      if (w_out_hs) begin
        if (w_out_end) begin
          for (int i = 0; i < N; i++) begin
            r_in_buf[i]  <= PAD;
            r_out_buf[i] <= PAD;
          end
          r_wr_cnt    <= '0;
          r_rd_cnt    <= '0;
          r_frame_len <= '0;
          r_sort_cnt  <= '0;
        end else begin
          r_rd_cnt <= r_rd_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_oddeven_sort_ctrl.sv
// Bench for oddeven_sort_ctrl: a latency-accurate sort core model plus a
// sorted-queue reference for every frame.
module tb_oddeven_sort_ctrl;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int SC = N;

  typedef logic [W-1:0] q_t[$];

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_last = 1'b0;
  logic           in_ready;
  logic           core_load;
  logic [W*N-1:0] core_data_in;
  logic [W*N-1:0] core_data_out = '0;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready = 1'b0;
  logic           busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int load_cnt = 0;

  oddeven_sort_ctrl #(.N(N), .W(W), .SORT_CYCLES(SC), .PAD({W{1'b1}})) dut (
    .clk(clk), .rstb(rstb), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .core_load(core_load), .core_data_in(core_data_in), .core_data_out(core_data_out),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (core_load) load_cnt <= load_cnt + 1;

  function automatic logic [W*N-1:0] sort_word(input logic [W*N-1:0] w);
    logic [W-1:0]   q[$];
    logic [W*N-1:0] r;
    for (int i = 0; i < N; i++) q.push_back(w[W*i +: W]);
    q.sort();
    for (int i = 0; i < N; i++) r[W*i +: W] = q[i];
    return r;
  endfunction

  function automatic logic [W*N-1:0] junk_word();
    logic [W*N-1:0] r;
    for (int i = 0; i < N; i++) r[W*i +: W] = W'($urandom);
    return r;
  endfunction

  // Sort core: output is garbage until SC cycles after the load sample.
  logic [W*N-1:0] core_lat = '0;
  int             core_cnt = 0;
  always @(posedge clk) begin
    if (core_load) begin
      core_lat      <= sort_word(core_data_in);
      core_cnt      <= SC;
      core_data_out <= junk_word();
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_data_out <= core_lat;
    end
  end

  function automatic q_t ref_sort(input q_t q);
    q_t r;
    r = q;
    r.sort();
    return r;
  endfunction

  function automatic int first_diff(input q_t a, input q_t b);
    if (a.size() != b.size()) return -2;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic q_t rand_frame(input int len);
    q_t r;
    for (int i = 0; i < len; i++) r.push_back(W'($urandom_range(255)));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input q_t el, input bit mark_last, input bit hold,
                            output int hs_cyc, output int to);
    int guard;
    to = 0;
    for (int i = 0; i < el.size(); i++) begin
      in_valid = 1'b1;
      in_data  = el[i];
      in_last  = mark_last && (i == el.size() - 1);
      guard    = 0;
      while (in_ready !== 1'b1 && guard < 500) begin
        tick();
        guard++;
      end
      if (guard >= 500) to++;
      tick();
    end
    hs_cyc  = cyc;
    in_last = 1'b0;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic collect(input int pct, output q_t got, output int last_idx,
                         output int first_cyc, output int viol, output int busy_low,
                         output int rdy_busy, output int to);
    bit           stalled;
    bit           done;
    logic [W-1:0] pd;
    logic         pl;
    got = {};
    last_idx = -1; first_cyc = -1; viol = 0; busy_low = 0; rdy_busy = 0;
    stalled = 1'b0; done = 1'b0; pd = '0; pl = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      out_ready = ($urandom_range(99) < pct);
      if (stalled && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)) viol++;
      if (busy !== 1'b1) busy_low++;
      if (in_ready !== 1'b0) rdy_busy++;
      if (out_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
      if (out_valid === 1'b1 && out_ready) begin
        got.push_back(out_data);
        if (out_last === 1'b1) begin
          if (last_idx < 0) last_idx = got.size() - 1;
          done = 1'b1;
        end
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      pd = out_data;
      pl = out_last;
      tick();
    end
    to = done ? 0 : 1;
    out_ready = 1'b0;
    $display("[TB] frame out: %0d elements at cycle %0d", got.size(), cyc);
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    tick(); tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (core_load !== 1'b0) begin fails++; $display("FAIL reset_core_load got=%b exp=0", core_load); end
    tests++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin fails++; $display("FAIL reset_out got=%b%b exp=00", out_valid, out_last); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    tests++; if (core_data_in !== {N{8'hFF}}) begin fails++; $display("FAIL reset_pad got=%h exp=all FF", core_data_in); end
    rstb = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    q_t el, exp, got;
    int hs, to, to2, li, fc, viol, bl, rb, l0, d;
    el  = '{8'hAB,8'h15,8'h43,8'h54,8'h05,8'h18,8'hEF,8'h00,8'hFA,8'hBC,8'h63,8'h58,8'h12,8'h33,8'h99,8'h15};
    exp = '{8'h00,8'h05,8'h12,8'h15,8'h15,8'h18,8'h33,8'h43,8'h54,8'h58,8'h63,8'h99,8'hAB,8'hBC,8'hEF,8'hFA};
    l0 = load_cnt;
    send_frame(el, 1'b0, 1'b0, hs, to);
    collect(100, got, li, fc, viol, bl, rb, to2);
    d = first_diff(got, exp);
    tests++; if (to + to2 !== 0) begin fails++; $display("FAIL full_timeout got=%0d exp=0", to + to2); end
    tests++; if (d !== -1) begin fails++; $display("FAIL full_stream idx=%0d got_size=%0d exp_size=16", d, got.size()); end
    tests++; if (li !== 15) begin fails++; $display("FAIL full_last_pos got=%0d exp=15", li); end
    tests++; if (fc - hs !== SC + 2) begin fails++; $display("FAIL latency got=%0d exp=%0d", fc - hs, SC + 2); end
    tests++; if (load_cnt - l0 !== 1) begin fails++; $display("FAIL core_load_width got=%0d exp=1", load_cnt - l0); end
  endtask

  task automatic test_short_frame();
    q_t el, exp, got;
    int hs, to, to2, li, fc, viol, bl, rb, d;
    el  = '{8'h40, 8'h10, 8'h20};
    exp = '{8'h10, 8'h20, 8'h40};
    send_frame(el, 1'b1, 1'b0, hs, to);
    collect(100, got, li, fc, viol, bl, rb, to2);
    d = first_diff(got, exp);
    tests++; if (d !== -1 || to + to2 !== 0) begin fails++; $display("FAIL short_stream idx=%0d got_size=%0d exp_size=3", d, got.size()); end
    tests++; if (li !== 2) begin fails++; $display("FAIL short_last_pos got=%0d exp=2", li); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL short_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_backpressure();
    q_t el, exp, got;
    int hs, to, to2, li, fc, viol, bl, rb, d;
    el = '{8'hAB,8'h15,8'h43,8'h54,8'h05,8'h18,8'hEF,8'h00,8'hFA,8'hBC,8'h63,8'h58,8'h12,8'h33,8'h99,8'h15};
    exp = ref_sort(el);
    send_frame(el, 1'b0, 1'b0, hs, to);
    collect(50, got, li, fc, viol, bl, rb, to2);
    d = first_diff(got, exp);
    tests++; if (d !== -1 || to + to2 !== 0) begin fails++; $display("FAIL bp_stream idx=%0d got_size=%0d", d, got.size()); end
    tests++; if (viol !== 0) begin fails++; $display("FAIL bp_stable got=%0d violations exp=0", viol); end
    tests++; if (bl !== 0) begin fails++; $display("FAIL bp_busy got=%0d low cycles exp=0", bl); end
  endtask

  task automatic test_random();
    q_t el, exp, got;
    int hs, to, to2, li, fc, viol, bl, rb, d, len;
    bit ml;
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(N, 1);
      ml  = (len < N) ? 1'b1 : 1'($urandom_range(1));
      el  = rand_frame(len);
      exp = ref_sort(el);
      send_frame(el, ml, 1'b0, hs, to);
      collect($urandom_range(100, 30), got, li, fc, viol, bl, rb, to2);
      d = first_diff(got, exp);
      tests++; if (d !== -1 || to + to2 !== 0) begin fails++; $display("FAIL rand_stream frame=%0d idx=%0d got_size=%0d exp_size=%0d", f, d, got.size(), len); end
      tests++; if (li !== len - 1 || viol !== 0 || rb !== 0) begin fails++; $display("FAIL rand_ctrl frame=%0d last=%0d exp=%0d viol=%0d ready_busy=%0d", f, li, len - 1, viol, rb); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rand_ready_after frame=%0d got=%b exp=1", f, in_ready); end
    end
  endtask

  task automatic test_flush_reset();
    q_t el, exp, got;
    int hs, to, to2, li, fc, viol, bl, rb, d, guard;
    exp = '{8'h01, 8'h02};
    el = rand_frame(5);
    send_frame(el, 1'b1, 1'b0, hs, to);
    repeat (5) tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_pre_busy got=%b exp=1", busy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_sort busy=%b in_ready=%b out_valid=%b exp=0,1,0", busy, in_ready, out_valid); end
    tests++; if (core_data_in !== {N{8'hFF}}) begin fails++; $display("FAIL flush_pad got=%h exp=all FF", core_data_in); end
    in_valid = 1'b1; in_data = 8'hAA; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    el = '{8'h02, 8'h01};
    send_frame(el, 1'b1, 1'b0, hs, to);
    collect(100, got, li, fc, viol, bl, rb, to2);
    d = first_diff(got, exp);
    tests++; if (d !== -1 || to + to2 !== 0) begin fails++; $display("FAIL flush_next_frame idx=%0d got_size=%0d exp_size=2", d, got.size()); end
    el = rand_frame(N);
    send_frame(el, 1'b0, 1'b0, hs, to);
    out_ready = 1'b1;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 200) begin tick(); guard++; end
    repeat (3) tick();
    tests++; if (out_valid !== 1'b1 || guard >= 200) begin fails++; $display("FAIL drain_reach got=%b exp=1", out_valid); end
    #2 rstb = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_drain_async out_valid=%b busy=%b exp=0,0", out_valid, busy); end
    tick();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL reset_drain_edge out_valid=%b in_ready=%b exp=0,1", out_valid, in_ready); end
    rstb = 1'b1;
    out_ready = 1'b0;
    tick();
    el = '{8'h02, 8'h01};
    send_frame(el, 1'b1, 1'b0, hs, to);
    collect(100, got, li, fc, viol, bl, rb, to2);
    d = first_diff(got, exp);
    tests++; if (d !== -1 || to + to2 !== 0 || li !== 1) begin fails++; $display("FAIL reset_next_frame idx=%0d got_size=%0d last=%0d exp=-1,2,1", d, got.size(), li); end
  endtask

  task automatic test_back_to_back();
    q_t a, b, ea, eb, got;
    int hs, to, to2, li, fc, viol, bl, rb, d;
    a = rand_frame(N);
    b = rand_frame(N);
    ea = ref_sort(a);
    eb = ref_sort(b);
    send_frame(a, 1'b0, 1'b1, hs, to);
    in_data = b[0];
    collect(100, got, li, fc, viol, bl, rb, to2);
    d = first_diff(got, ea);
    tests++; if (d !== -1 || to + to2 !== 0) begin fails++; $display("FAIL b2b_first idx=%0d got_size=%0d", d, got.size()); end
    tests++; if (rb !== 0) begin fails++; $display("FAIL b2b_ready_busy got=%0d cycles exp=0", rb); end
    send_frame(b, 1'b0, 1'b0, hs, to);
    collect(70, got, li, fc, viol, bl, rb, to2);
    d = first_diff(got, eb);
    tests++; if (d !== -1 || to + to2 !== 0 || li !== N - 1) begin fails++; $display("FAIL b2b_second idx=%0d got_size=%0d last=%0d", d, got.size(), li); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_random();
    test_flush_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
